// File: rtl/s3_writeback_regfile.sv
// Integer register file fed by the S3 write-back bundle, with two registered
// read ports for stage 2 and a same-cycle write-to-read bypass.
module s3_writeback_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  S3_WriteEnable,
  input  logic [ADDR_WIDTH-1:0] S3_WriteSelect,
  input  logic [DATA_WIDTH-1:0] ALUOut,
  input  logic [ADDR_WIDTH-1:0] S1_ReadSelect1,
  input  logic [ADDR_WIDTH-1:0] S1_ReadSelect2,
  input  logic                  S1_Stall,
  output logic [DATA_WIDTH-1:0] S2_ReadData1,
  output logic [DATA_WIDTH-1:0] S2_ReadData2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  write_hit;
  logic [DATA_WIDTH-1:0] next_rd1;
  logic [DATA_WIDTH-1:0] next_rd2;

  // Writes to r0 are dropped when it is hardwired to zero.
  assign write_hit = S3_WriteEnable && !(ZERO_REG && (S3_WriteSelect == '0));

  // Read value seen by stage 2: zero register, then bypass, then storage.
  function automatic logic [DATA_WIDTH-1:0] read_value(input logic [ADDR_WIDTH-1:0] sel);
    logic [DATA_WIDTH-1:0] value;
    if (ZERO_REG && (sel == '0))
      value = '0;
    else if (S3_WriteEnable && (S3_WriteSelect == sel))
      value = ALUOut;
    else
      value = regs[sel];
    return value;
  endfunction

  always_comb begin
    next_rd1 = read_value(S1_ReadSelect1);
    next_rd2 = read_value(S1_ReadSelect2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (write_hit) begin
      regs[S3_WriteSelect] <= ALUOut;
    end
  end

  // Stall freezes only the read outputs; the write path above keeps running.
  always_ff @(posedge clk) begin
    if (rst) begin
      S2_ReadData1 <= '0;
      S2_ReadData2 <= '0;
    end else if (!S1_Stall) begin
      S2_ReadData1 <= next_rd1;
      S2_ReadData2 <= next_rd2;
    end
  end

endmodule

// File: tb/tb_s3_writeback_regfile.sv
// Directed bench for s3_writeback_regfile: driver queues hand-computed read
// results, a monitor compares them one cycle after each issue.
module tb_s3_writeback_regfile;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] wsel;
  logic [W-1:0]  alu;
  logic [AW-1:0] rsel1;
  logic [AW-1:0] rsel2;
  logic          stall;
  logic [W-1:0]  rd1;
  logic [W-1:0]  rd2;

  // {check_enable, expected rd1, expected rd2}
  logic [2*W:0] exp_q[$];
  int           checks;
  int           errors;

  s3_writeback_regfile #(.DATA_WIDTH(W), .ADDR_WIDTH(AW), .ZERO_REG(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .S3_WriteEnable (we),
    .S3_WriteSelect (wsel),
    .ALUOut         (alu),
    .S1_ReadSelect1 (rsel1),
    .S1_ReadSelect2 (rsel2),
    .S1_Stall       (stall),
    .S2_ReadData1   (rd1),
    .S2_ReadData2   (rd2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: apply one cycle of inputs and queue the expected outputs
  task automatic step(input logic r, input logic w_en, input logic [AW-1:0] w_sel,
                      input logic [W-1:0] w_data, input logic [AW-1:0] s1,
                      input logic [AW-1:0] s2, input logic stl,
                      input logic [W-1:0] e1, input logic [W-1:0] e2);
    @(negedge clk);
    rst   = r;
    we    = w_en;
    wsel  = w_sel;
    alu   = w_data;
    rsel1 = s1;
    rsel2 = s2;
    stall = stl;
    exp_q.push_back({1'b1, e1, e2});
  endtask

  // monitor / scoreboard
  initial begin
    logic [2*W:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e[2*W]) begin
          checks++;
          if (rd1 !== e[2*W-1:W]) begin
            errors++;
            $display("FAIL rd1 at %0t: got %h expected %h", $time, rd1, e[2*W-1:W]);
          end
          checks++;
          if (rd2 !== e[W-1:0]) begin
            errors++;
            $display("FAIL rd2 at %0t: got %h expected %h", $time, rd2, e[W-1:0]);
          end
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    checks = 0;
    errors = 0;
    rst = 1'b1; we = 1'b0; wsel = '0; alu = '0;
    rsel1 = '0; rsel2 = '0; stall = 1'b0;

    //   rst  we   wsel   alu            s1     s2     stall exp1           exp2
    // reset, then registers read zero
    step(1, 0, 5'd0,  32'h0,          5'd5,  5'd31, 0, 32'h0,          32'h0);
    step(0, 0, 5'd0,  32'h0,          5'd5,  5'd31, 0, 32'h0,          32'h0);
    // write r5, read it next cycle
    step(0, 1, 5'd5,  32'hDEADBEEF,   5'd0,  5'd0,  0, 32'h0,          32'h0);
    step(0, 0, 5'd0,  32'h0,          5'd5,  5'd31, 0, 32'hDEADBEEF,   32'h0);
    // same-cycle bypass on both ports
    step(0, 1, 5'd7,  32'h12345678,   5'd7,  5'd7,  0, 32'h12345678,   32'h12345678);
    step(0, 0, 5'd0,  32'h0,          5'd7,  5'd5,  0, 32'h12345678,   32'hDEADBEEF);
    // top register boundary
    step(0, 1, 5'd31, 32'hCAFEF00D,   5'd31, 5'd30, 0, 32'hCAFEF00D,   32'h0);
    step(0, 0, 5'd0,  32'h0,          5'd30, 5'd31, 0, 32'h0,          32'hCAFEF00D);
    // r0 write dropped, no bypass for r0
    step(0, 1, 5'd0,  32'hFFFFFFFF,   5'd0,  5'd0,  0, 32'h0,          32'h0);
    step(0, 0, 5'd0,  32'h0,          5'd0,  5'd7,  0, 32'h0,          32'h12345678);
    // WE=0: no write, no bypass
    step(0, 0, 5'd3,  32'hAA,         5'd3,  5'd3,  0, 32'h0,          32'h0);
    step(0, 0, 5'd0,  32'h0,          5'd3,  5'd5,  0, 32'h0,          32'hDEADBEEF);
    // stall holds outputs while the write goes through
    step(0, 0, 5'd0,  32'h0,          5'd5,  5'd5,  0, 32'hDEADBEEF,   32'hDEADBEEF);
    step(0, 1, 5'd5,  32'h1,          5'd5,  5'd5,  1, 32'hDEADBEEF,   32'hDEADBEEF);
    step(0, 0, 5'd0,  32'h0,          5'd7,  5'd31, 1, 32'hDEADBEEF,   32'hDEADBEEF);
    step(0, 0, 5'd0,  32'h0,          5'd5,  5'd5,  0, 32'h1,          32'h1);
    // write r9, then reset in the same cycle as a write to r10
    step(0, 1, 5'd9,  32'h55,         5'd9,  5'd9,  0, 32'h55,         32'h55);
    step(1, 1, 5'd10, 32'h66,         5'd9,  5'd10, 0, 32'h0,          32'h0);
    step(0, 0, 5'd0,  32'h0,          5'd9,  5'd10, 0, 32'h0,          32'h0);
    step(0, 0, 5'd0,  32'h0,          5'd5,  5'd31, 0, 32'h0,          32'h0);

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
